// File: rtl/k2_pkg.sv
// Shared types and constants for the pc_sequencer instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, instruction field positions, memory-op test.
package k2_pkg;

  typedef enum logic [1:0] {
    EXEC = 2'd0,
    MEM  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Instruction word layout: [7]=J, [6]=C, [5:4]=D, [3:0]=imm
  localparam int INSTR_W    = 8;
  localparam int J_BIT      = 7;
  localparam int C_BIT      = 6;
  localparam int D_HI       = 5;
  localparam int D_LO       = 4;
  localparam int IMM_HI     = 3;
  localparam int IMM_LO     = 0;
  localparam int IMM_W      = IMM_HI - IMM_LO + 1;

  // Destination code that, together with C=1, marks a memory operation
  localparam logic [1:0] D_MEM_OP = 2'b11;

  function automatic logic is_mem_op(input logic [INSTR_W-1:0] instr);
    return instr[C_BIT] && (instr[D_HI:D_LO] == D_MEM_OP);
  endfunction

endpackage

// File: rtl/k2_flag_reg.sv
// Zero/carry flag holding register with load enable.
// Latency: 1 cycle from load to zf/cf.
// Backpressure: none; caller gates load (stall/state) before it reaches here.
// Ports: clk, rst (sync, active-high), load, zf_in/cf_in -> zf/cf.
module k2_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic zf_in,
  input  logic cf_in,
  output logic zf,
  output logic cf
);

  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if (load) begin
      zf <= zf_in;
      cf <= cf_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: EXEC/MEM/HALT FSM, flag latch, retired counter.
// Latency: all outputs registered, updated on the edge after the inputs.
// Backpressure: stall=1 freezes every register; rst overrides stall.
// Ports: instr/jcf steer pc; alu_zf/alu_cf/flag_update feed flags;
//        pc, s_reg (MEM phase), zf_reg, cf_reg, halted, retired are outputs.
module pc_sequencer
  import k2_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               jcf,
  input  logic               alu_zf,
  input  logic               alu_cf,
  input  logic               flag_update,
  input  logic               stall,
  output logic [PC_W-1:0]    pc,
  output logic               s_reg,
  output logic               zf_reg,
  output logic               cf_reg,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  state_t            state;
  logic              mem_op;
  logic [PC_W-1:0]   imm_ext;
  logic [PC_W-1:0]   pc_inc;
  logic [CNT_W-1:0]  ret_inc;
  logic              flag_load;
  logic              unused_j;

  // The J bit is already folded into jcf by the jump-condition logic.
  assign unused_j  = instr[J_BIT];

  assign mem_op    = is_mem_op(instr);
  assign imm_ext   = PC_W'(instr[IMM_HI:IMM_LO]);
  // Natural overflow gives the required wrap from all-ones to zero.
  assign pc_inc    = pc + PC_W'(1);
  // Saturating increment: the counter sticks at all-ones.
  assign ret_inc   = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);
  assign flag_load = flag_update && !stall && (state == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EXEC;
      pc      <= '0;
      s_reg   <= 1'b0;
      halted  <= 1'b0;
      retired <= '0;
    end else if (!stall) begin
      case (state)
        EXEC: begin
          if (mem_op) begin
            // pc held; the memory phase retires the instruction
            state <= MEM;
            s_reg <= 1'b1;
          end else if (jcf && (imm_ext == pc)) begin
            // Jump-to-self is the program's halt idiom
            state   <= HALT;
            halted  <= 1'b1;
            retired <= ret_inc;
          end else begin
            pc      <= jcf ? imm_ext : pc_inc;
            retired <= ret_inc;
          end
        end
        MEM: begin
          state   <= EXEC;
          s_reg   <= 1'b0;
          pc      <= pc_inc;
          retired <= ret_inc;
        end
        HALT: begin
          // Only rst leaves HALT
        end
        default: begin
          state  <= EXEC;
          s_reg  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  k2_flag_reg u_flag_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (flag_load),
    .zf_in (alu_zf),
    .cf_in (alu_cf),
    .zf    (zf_reg),
    .cf    (cf_reg)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises stall in EXEC and MEM.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  instr;
  logic        jcf;
  logic        alu_zf;
  logic        alu_cf;
  logic        flag_update;
  logic        stall;
  logic [3:0]  pc;
  logic        s_reg;
  logic        zf_reg;
  logic        cf_reg;
  logic        halted;
  logic [15:0] retired;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [7:0] I_ALU  = 8'h00;  // C=0: plain ALU op
  localparam logic [7:0] I_MEM  = 8'h70;  // C=1, D=11
  localparam logic [7:0] I_JMP9 = 8'h89;  // J=1, imm=9

  pc_sequencer #(.PC_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .jcf         (jcf),
    .alu_zf      (alu_zf),
    .alu_cf      (alu_cf),
    .flag_update (flag_update),
    .stall       (stall),
    .pc          (pc),
    .s_reg       (s_reg),
    .zf_reg      (zf_reg),
    .cf_reg      (cf_reg),
    .halted      (halted),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] i, input logic j, input logic st);
    instr = i;
    jcf   = j;
    stall = st;
  endtask

  initial begin
    rst = 1'b1; instr = I_ALU; jcf = 1'b0; alu_zf = 1'b0; alu_cf = 1'b0;
    flag_update = 1'b0; stall = 1'b0;

    // Reset state
    step();
    chk_eq("rst_pc",      pc,      0);
    chk_eq("rst_s",       s_reg,   0);
    chk_eq("rst_zf",      zf_reg,  0);
    chk_eq("rst_cf",      cf_reg,  0);
    chk_eq("rst_halt",    halted,  0);
    chk_eq("rst_retired", retired, 0);
    rst = 1'b0;

    // 16 sequential ALU instructions: pc walks 1..15 then wraps to 0
    drive(I_ALU, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_eq($sformatf("seq_pc%0d", k), pc, k % 16);
    end
    chk_eq("seq_retired", retired, 16);

    // Advance to pc=3, then a memory op
    for (int k = 0; k < 3; k++) step();
    chk_eq("pre_mem_pc", pc, 3);
    drive(I_MEM, 1'b0, 1'b0);
    step();
    chk_eq("mem_s",       s_reg,   1);
    chk_eq("mem_pc",      pc,      3);
    chk_eq("mem_retired", retired, 19);
    drive(I_JMP9, 1'b1, 1'b0);  // jcf must be ignored in MEM
    step();
    chk_eq("post_mem_s",       s_reg,   0);
    chk_eq("post_mem_pc",      pc,      4);
    chk_eq("post_mem_retired", retired, 20);

    // Flag load in EXEC at pc=4
    drive(I_ALU, 1'b0, 1'b0);
    flag_update = 1'b1; alu_zf = 1'b1; alu_cf = 1'b0;
    step();
    chk_eq("flag_zf", zf_reg, 1);
    chk_eq("flag_cf", cf_reg, 0);
    chk_eq("flag_pc", pc,     5);

    // Stalled jump with flag_update: nothing moves
    drive(I_JMP9, 1'b1, 1'b1);
    alu_zf = 1'b0; alu_cf = 1'b1;
    step();
    chk_eq("stall_pc",      pc,      5);
    chk_eq("stall_zf",      zf_reg,  1);
    chk_eq("stall_cf",      cf_reg,  0);
    chk_eq("stall_retired", retired, 21);

    // Jump to 9
    flag_update = 1'b0;
    drive(I_JMP9, 1'b1, 1'b0);
    step();
    chk_eq("jmp_pc",      pc,      9);
    chk_eq("jmp_halt",    halted,  0);
    chk_eq("jmp_retired", retired, 22);

    // Jump-to-self at pc=9 halts
    step();
    chk_eq("halt_flag",    halted,  1);
    chk_eq("halt_pc",      pc,      9);
    chk_eq("halt_retired", retired, 23);

    // Ten cycles in HALT with jcf and flag_update active
    flag_update = 1'b1; alu_zf = 1'b0; alu_cf = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive({4'h8, 4'(k)}, 1'b1, 1'b0);
      step();
      chk_eq($sformatf("halt_hold_pc%0d", k), pc, 9);
    end
    chk_eq("halt_hold_flag",    halted,  1);
    chk_eq("halt_hold_retired", retired, 23);
    chk_eq("halt_hold_zf",      zf_reg,  1);
    chk_eq("halt_hold_cf",      cf_reg,  0);
    flag_update = 1'b0;

    // Reset out of HALT
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("rst_halt_halted", halted,  0);
    chk_eq("rst_halt_pc",     pc,      0);
    chk_eq("rst_halt_zf",     zf_reg,  0);
    chk_eq("rst_halt_ret",    retired, 0);

    // pc=2, enter MEM, stall 5 cycles, then reset while stalled
    drive(I_ALU, 1'b0, 1'b0);
    step(); step();
    drive(I_MEM, 1'b0, 1'b0);
    step();
    chk_eq("mstall_enter_s", s_reg, 1);
    drive(I_MEM, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_eq($sformatf("mstall_s%0d", k), s_reg, 1);
      chk_eq($sformatf("mstall_pc%0d", k), pc, 2);
      chk_eq($sformatf("mstall_ret%0d", k), retired, 2);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("mstall_rst_pc", pc,    0);
    chk_eq("mstall_rst_s",  s_reg, 0);

    // Saturation of the retired counter
    drive(I_ALU, 1'b0, 1'b0);
    for (int k = 0; k < 16'hFFFE; k++) @(posedge clk);
    #1;
    chk_eq("sat_pre", retired, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_eq($sformatf("sat_%0d", k), retired, 16'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 4, program-counter width (16-word instruction ROM).
REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr  input  8  current ROM word at pc: [7]=J, [6]=C, [5:4]=D, [3:0]=imm.
REQ-006 SHALL have port jcf  input  1  jump-taken indication from the jump-condition logic.
REQ-007 SHALL have port alu_zf  input  1  raw ALU zero flag.
REQ-008 SHALL have port alu_cf  input  1  raw ALU carry flag.
REQ-009 SHALL have port flag_update  input  1  latch ALU flags this cycle.
REQ-010 SHALL have port stall  input  1  freeze all state except reset.
REQ-011 SHALL have port pc  output  PC_W  instruction address.
REQ-012 SHALL have port s_reg  output  1  phase: 0 = EXEC, 1 = MEM.
REQ-013 SHALL have port zf_reg  output  1  latched zero flag.
REQ-014 SHALL have port cf_reg  output  1  latched carry flag.
REQ-015 SHALL have port halted  output  1  high in HALT state.
REQ-016 SHALL have port retired  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL implement FSM states EXEC, MEM, HALT; all outputs registered.
REQ-018 EXEC, stall=0, instr C=1 and D=2'b11 (memory op): SHALL go to MEM; pc held.
REQ-019 EXEC, stall=0, not memory op, jcf=0: SHALL stay in EXEC; pc <= pc+1, wrapping 2^PC_W-1 -> 0.
REQ-020 EXEC, stall=0, not memory op, jcf=1, imm != pc: SHALL stay in EXEC; pc <= imm.
REQ-021 EXEC, stall=0, not memory op, jcf=1, imm == pc (jump-to-self): SHALL go to HALT; pc unchanged.
REQ-022 MEM, stall=0: SHALL go to EXEC; pc <= pc+1 with wrap; jcf ignored.
REQ-023 HALT SHALL be exited only by rst; pc, flags, retired frozen.
REQ-024 stall=1 SHALL hold state, pc, flags and retired in any state.
REQ-025 zf_reg/cf_reg SHALL load alu_zf/alu_cf when flag_update=1, stall=0, state EXEC; otherwise hold.
REQ-026 s_reg SHALL be 1 exactly while in MEM; halted 1 exactly while in HALT.
REQ-027 retired SHALL increment by 1 on each EXEC->EXEC, MEM->EXEC and EXEC->HALT transition; EXEC->MEM does not count.
REQ-028 retired SHALL saturate at 2^CNT_W-1, no wrap.

Reset
REQ-029 rst=1 SHALL override stall and all events, including mid-MEM and HALT.
REQ-030 Next edge after rst=1: state EXEC, pc=0, s_reg=0, zf_reg=0, cf_reg=0, halted=0, retired=0.

Structure
REQ-031 Shared package k2_pkg SHALL hold the state enum (EXEC, MEM, HALT), instr field bit positions, and the D=2'b11 memory-op encoding.
REQ-032 A sub-module k2_flag_reg (two flag flops with load enable and sync reset) SHALL hold zf_reg/cf_reg; the rest is flat.

Verification
REQ-033 rst, then 16 non-jump ALU instrs, jcf=0 -> pc 0..15 then 0, retired=16.
REQ-034 pc=3, instr C=1 D=11 -> s_reg=1 for one cycle, pc stays 3, then pc=4, retired +1 total.
REQ-035 pc=5, jcf=1, imm=9 -> pc=9 next cycle; jcf=1, imm=9 at pc=9 -> halted=1, pc=9 held for 10 cycles despite jcf.
REQ-036 flag_update=1 with alu_zf=1, alu_cf=0 in EXEC -> zf_reg=1, cf_reg=0; flag_update=1 with stall=1 -> flags unchanged.
REQ-037 stall=1 for 5 cycles in MEM -> s_reg stays 1, pc and retired constant; rst asserted while stalled in MEM -> pc=0, s_reg=0 next edge.
REQ-038 Preload retired to 0xFFFE via 0xFFFE retirements, then 3 more -> retired=0xFFFF.
